// File: rtl/amiga_clock_phase_gen.sv
// amiga_clock_phase_gen
//
// Derives the Amiga bus clock set (C7M, CDAC, CCK, CCKQ) from the 28 MHz
// master clock. The block also produces single-cycle enable strobes and a
// phase index, so downstream logic can run on hclkin alone and use enables.
// After reset it holds all outputs idle for a startup period. A resync input
// realigns the phase counter to an external reference.
//
// Ports:
//   hclkin      in   master clock (28.375 MHz PAL / 28.636 MHz NTSC)
//   resetn      in   asynchronous active-low reset
//   resync_req  in   one-cycle pulse; the next phase becomes 0
//   ready       out  high once the startup hold-off has completed
//   phase       out  current phase index 0..7
//   c7m         out  7 MHz clock, high in phases 0,1,4,5
//   cdac        out  C7M delayed by one cycle, high in phases 1,2,5,6
//   cck         out  colour clock, high in phases 0..3
//   cckq        out  CCK delayed by two cycles, high in phases 2..5
//   cck_rise    out  strobe in phase 0
//   cck_fall    out  strobe in phase 4
//   c7m_rise    out  strobe in phases 0 and 4
//   sync_err    out  sticky: a resync moved the phase away from its natural wrap
//
// State table:
//   state       | meaning
//   ST_STARTUP  | hold-off after reset; phase held at 0, all outputs idle
//   ST_RUN      | free-running phase counter, outputs decoded from phase

module amiga_clock_phase_gen #(
    parameter int STARTUP_CYCLES = 16
) (
    input  logic       hclkin,
    input  logic       resetn,
    input  logic       resync_req,
    output logic       ready,
    output logic [2:0] phase,
    output logic       c7m,
    output logic       cdac,
    output logic       cck,
    output logic       cckq,
    output logic       cck_rise,
    output logic       cck_fall,
    output logic       c7m_rise,
    output logic       sync_err
);

    localparam int CNT_W = (STARTUP_CYCLES < 1) ? 1 : $clog2(STARTUP_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(STARTUP_CYCLES);

    localparam logic [0:0] ST_STARTUP = 1'b0;
    localparam logic [0:0] ST_RUN     = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_next;
    logic [CNT_W-1:0] start_cnt;
    logic [CNT_W-1:0] start_cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic [2:0]       phase_next;
    logic             sync_err_next;
    logic             run_next;

    assign cnt_inc = start_cnt + CNT_W'(1);

    always_comb begin
        state_next     = state;
        start_cnt_next = start_cnt;
        phase_next     = phase;
        sync_err_next  = sync_err;
        if (state == ST_STARTUP) begin
            // resync_req is ignored here; the phase stays parked at 0.
            phase_next     = 3'd0;
            start_cnt_next = cnt_inc;
            if (cnt_inc == CNT_TC) begin
                state_next = ST_RUN;
            end
        end else begin
            if (resync_req) begin
                phase_next = 3'd0;
                // A resync in phase 7 matches the natural wrap, so it is not an error.
                if (phase != 3'd7) begin
                    sync_err_next = 1'b1;
                end
            end else begin
                phase_next = phase + 3'd1;
            end
        end
    end

    assign run_next = (state_next == ST_RUN);

    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_STARTUP;
            start_cnt <= '0;
        end else begin
            state     <= state_next;
            start_cnt <= start_cnt_next;
        end
    end

    // Every output register is decoded from phase_next, so it stays aligned
    // with the registered phase value in the same cycle.
    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            ready    <= 1'b0;
            phase    <= 3'd0;
            c7m      <= 1'b0;
            cdac     <= 1'b0;
            cck      <= 1'b0;
            cckq     <= 1'b0;
            cck_rise <= 1'b0;
            cck_fall <= 1'b0;
            c7m_rise <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            ready    <= run_next;
            phase    <= phase_next;
            c7m      <= run_next & ~phase_next[1];
            cdac     <= run_next & (phase_next[1] ^ phase_next[0]);
            cck      <= run_next & ~phase_next[2];
            cckq     <= run_next & (phase_next[2] ^ phase_next[1]);
            cck_rise <= run_next & (phase_next == 3'd0);
            cck_fall <= run_next & (phase_next == 3'd4);
            c7m_rise <= run_next & (phase_next[1:0] == 2'd0);
            sync_err <= sync_err_next;
        end
    end

endmodule

// File: tb/tb_amiga_clock_phase_gen.sv
module tb_amiga_clock_phase_gen;

    logic       hclkin;
    logic       resetn;
    logic       resync_req;
    logic       ready;
    logic [2:0] phase;
    logic       c7m;
    logic       cdac;
    logic       cck;
    logic       cckq;
    logic       cck_rise;
    logic       cck_fall;
    logic       c7m_rise;
    logic       sync_err;

    int checks = 0;
    int errors = 0;

    amiga_clock_phase_gen #(.STARTUP_CYCLES(4)) dut (
        .hclkin     (hclkin),
        .resetn     (resetn),
        .resync_req (resync_req),
        .ready      (ready),
        .phase      (phase),
        .c7m        (c7m),
        .cdac       (cdac),
        .cck        (cck),
        .cckq       (cckq),
        .cck_rise   (cck_rise),
        .cck_fall   (cck_fall),
        .c7m_rise   (c7m_rise),
        .sync_err   (sync_err)
    );

    initial hclkin = 1'b0;
    always #5 hclkin = ~hclkin;

    // One record per phase: input applied and the expected decoded outputs.
    typedef struct {
        logic       resync;
        logic [2:0] ph;
        logic       c7m;
        logic       cdac;
        logic       cck;
        logic       cckq;
        logic       rise;
        logic       fall;
        logic       c7r;
    } vec_t;

    vec_t tab [8];

    // Packed view: {ready, sync_err, phase, c7m, cdac, cck, cckq, cck_rise, cck_fall, c7m_rise}
    function automatic logic [11:0] actual();
        return {ready, sync_err, phase, c7m, cdac, cck, cckq, cck_rise, cck_fall, c7m_rise};
    endfunction

    function automatic logic [11:0] expect_of(vec_t v, logic rdy, logic serr);
        return {rdy, serr, v.ph, v.c7m, v.cdac, v.cck, v.cckq, v.rise, v.fall, v.c7r};
    endfunction

    task automatic check(input string name, input logic [11:0] exp);
        logic [11:0] act;
        act = actual();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (rdy,serr,ph,c7m,cdac,cck,cckq,rise,fall,c7r)",
                     name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclkin);
        #1;
    endtask

    initial begin
        //                resync ph    c7m  cdac cck  cckq rise fall c7r
        tab[0] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tab[1] = '{1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[2] = '{1'b0, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[3] = '{1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[4] = '{1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tab[5] = '{1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[6] = '{1'b0, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[7] = '{1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        resetn     = 1'b0;
        resync_req = 1'b0;
        tick();
        tick();
        check("reset_idle", 12'h000);

        // Release away from the clock edge; edges 1..3 still in hold-off.
        resetn = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check($sformatf("startup_edge%0d", e), 12'h000);
        end

        // Edge 4 is the first RUN cycle (phase 0), then free run.
        for (int i = 0; i < 64; i++) begin
            resync_req = tab[i % 8].resync;
            tick();
            check($sformatf("free_run_%0d", i), expect_of(tab[i % 8], 1'b1, 1'b0));
        end

        // Resync in phase 7: same as the natural wrap, no error.
        resync_req = 1'b1;
        tick();
        resync_req = 1'b0;
        check("resync_ph7", expect_of(tab[0], 1'b1, 1'b0));
        for (int i = 1; i < 8; i++) begin
            tick();
            check($sformatf("after_ph7_%0d", i), expect_of(tab[i], 1'b1, 1'b0));
        end

        // Advance to phase 3, then resync.
        for (int i = 0; i < 4; i++) tick();
        check("pre_resync_ph3", expect_of(tab[3], 1'b1, 1'b0));
        resync_req = 1'b1;
        tick();
        resync_req = 1'b0;
        check("resync_ph3", expect_of(tab[0], 1'b1, 1'b1));
        for (int i = 0; i < 100; i++) begin
            tick();
            check($sformatf("sticky_%0d", i), expect_of(tab[(i + 1) % 8], 1'b1, 1'b1));
        end

        // Mid-run reset between edges: outputs clear without a clock edge.
        #3;
        resetn = 1'b0;
        #1;
        check("async_reset", 12'h000);
        tick();
        check("reset_held", 12'h000);

        // Release with resync pulsed during hold-off: no effect.
        resetn     = 1'b1;
        resync_req = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check($sformatf("restart_edge%0d", e), 12'h000);
        end
        resync_req = 1'b0;
        tick();
        check("restart_run", expect_of(tab[0], 1'b1, 1'b0));

        // Back-to-back resync from phase 2.
        tick();
        tick();
        check("b2b_pre", expect_of(tab[2], 1'b1, 1'b0));
        resync_req = 1'b1;
        tick();
        check("b2b_first", expect_of(tab[0], 1'b1, 1'b1));
        tick();
        check("b2b_second", expect_of(tab[0], 1'b1, 1'b1));
        resync_req = 1'b0;
        tick();
        check("b2b_after", expect_of(tab[1], 1'b1, 1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
